// File: rtl/adder8_reg.sv
// Registered WIDTH-bit adder with carry-in, carry-out and two's-complement overflow.
// Carries come from 4-bit lookahead groups whose group carries ripple between groups.
module adder8_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NGROUPS = WIDTH / 4;

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] sum_next;
  logic             ovf_next;

  assign g    = a & b;
  assign p    = a ^ b;
  assign c[0] = cin;

  // Each group resolves its internal carries from its own carry-in only
  for (genvar k = 0; k < NGROUPS; k++) begin : grp
    localparam int B = 4 * k;
    logic ci;
    assign ci = c[B];

    assign c[B+1] = g[B] | (p[B] & ci);
    assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & ci);
    assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                  | (p[B+2] & p[B+1] & p[B] & ci);
    assign c[B+4] = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                  | (p[B+3] & p[B+2] & p[B+1] & g[B])
                  | (p[B+3] & p[B+2] & p[B+1] & p[B] & ci);
  end

  assign sum_next = p ^ c[WIDTH-1:0];
  assign ovf_next = (a[WIDTH-1] == b[WIDTH-1]) && (sum_next[WIDTH-1] != a[WIDTH-1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      sum  <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      sum  <= sum_next;
      cout <= c[WIDTH];
      ovf  <= ovf_next;
    end
  end

endmodule

// File: tb/tb_adder8_reg.sv
// Scoreboard bench for adder8_reg: the driver queues expected results from a signed/unsigned
// arithmetic model, and a monitor pops one entry per clock and compares against the DUT.
module tb_adder8_reg;

  typedef struct {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
    int         id;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       cin = 1'b0;
  logic [7:0] sum;
  logic       cout;
  logic       ovf;

  exp_t expq[$];
  int   compared = 0;
  int   mismatched = 0;
  int   issued = 0;

  adder8_reg #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .b   (b),
    .cin (cin),
    .sum (sum),
    .cout(cout),
    .ovf (ovf)
  );

  always #5 clk = ~clk;

  // Drive one vector for the coming rising edge and queue what that edge must produce
  task automatic applyStimulus(input logic r, input logic [7:0] va, input logic [7:0] vb,
                               input logic vc);
    exp_t e;
    int   total;
    int   stotal;
    @(negedge clk);
    rst = r;
    a   = va;
    b   = vb;
    cin = vc;
    total  = int'(va) + int'(vb) + int'(vc);
    stotal = int'($signed(va)) + int'($signed(vb)) + int'(vc);
    e.id = issued;
    issued++;
    if (r) begin
      e.sum  = 8'h00;
      e.cout = 1'b0;
      e.ovf  = 1'b0;
    end else begin
      e.sum  = total[7:0];
      e.cout = (total >= 256);
      e.ovf  = (stotal > 127) || (stotal < -128);
    end
    expq.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    compared++;
    if (sum !== e.sum || cout !== e.cout || ovf !== e.ovf) begin
      mismatched++;
      $display("[TB] FAIL result#%0d: got sum=%b cout=%b ovf=%b, expected sum=%b cout=%b ovf=%b",
               e.id, sum, cout, ovf, e.sum, e.cout, e.ovf);
    end
  endtask

  // Monitor: the DUT presents a fresh result after every edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) checkOutput(expq.pop_front());
    end
  end

  initial begin
    // Reset held with all-ones operands, then released
    applyStimulus(1'b1, 8'hFF, 8'hFF, 1'b1);
    applyStimulus(1'b1, 8'hFF, 8'hFF, 1'b1);
    applyStimulus(1'b0, 8'hFF, 8'hFF, 1'b1);
    // Directed arithmetic and overflow cases
    applyStimulus(1'b0, 8'b00000011, 8'b00000101, 1'b0);
    applyStimulus(1'b0, 8'b00000011, 8'b00000101, 1'b1);
    applyStimulus(1'b0, 8'hFF, 8'h01, 1'b0);
    applyStimulus(1'b0, 8'h7F, 8'h01, 1'b0);
    applyStimulus(1'b0, 8'b10101010, 8'b01010101, 1'b1);
    applyStimulus(1'b0, 8'b10000000, 8'b10000000, 1'b0);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b1);
    applyStimulus(1'b0, 8'h80, 8'h80, 1'b1);
    applyStimulus(1'b0, 8'h7F, 8'h7F, 1'b1);
    // Mid-stream reset discards the operands sampled with it
    applyStimulus(1'b1, 8'b00001111, 8'b00000001, 1'b0);
    applyStimulus(1'b0, 8'h12, 8'h34, 1'b1);
    // Every a/b pair once, with a random carry-in
    for (int i = 0; i < 65536; i++) begin
      applyStimulus(1'b0, i[15:8], i[7:0], 1'($urandom_range(0, 1)));
    end
    // Random vectors with occasional resets
    for (int i = 0; i < 2000; i++) begin
      applyStimulus(($urandom_range(0, 49) == 0), 8'($urandom), 8'($urandom),
                    1'($urandom_range(0, 1)));
    end
    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 10 && expq.size() > 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    if (expq.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL drain: got %0d results outstanding, expected 0", expq.size());
    end
    if (compared != issued) begin
      mismatched++;
      $display("[TB] FAIL count: got %0d checks, expected %0d", compared, issued);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/adder8_reg.md
Name: adder8_reg

Overview:
- Registered 8-bit binary adder with carry-in and carry-out, computing {cout, sum} = a + b + cin.
- Used as the arithmetic leaf block in datapaths, and as the regression target for file-driven vector benches.
- Benches apply one vector per clock, then compare the registered result one cycle later against a golden text model.
- Operands are unsigned; a signed-overflow flag is also provided for two's-complement users.

Parameters:
- WIDTH, 8, operand and sum width in bits. Must be a multiple of 4; the verified configuration is 8.

Ports:
- clk  input  1  rising-edge clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high; sampled on the rising edge of clk.
- a  input  WIDTH  operand A (unsigned).
- b  input  WIDTH  operand B (unsigned).
- cin  input  1  carry-in, weight 1.
- sum  output  WIDTH  registered low WIDTH bits of a+b+cin.
- cout  output  1  registered carry-out (bit WIDTH of a+b+cin).
- ovf  output  1  registered two's-complement overflow: (a[MSB]==b[MSB]) && (sum_next[MSB]!=a[MSB]).

Behaviour:
- Reset: on a rising edge with rst=1, sum=0, cout=0 and ovf=0. Inputs are ignored on that edge. Reset has priority over all inputs.
- Reset mid-stream: the result of the operands sampled on the reset edge is discarded. The first valid result appears one edge after the first edge with rst=0.
- Latency: exactly 1 clock. Operands sampled on edge N appear on sum/cout/ovf immediately after edge N.
- Outputs are held until the next rising edge. No combinational path from a/b/cin to any output.
- Throughput: one new operation per clock. There is no handshake and no stall; every non-reset edge captures new operands.
- Arithmetic:
  - {cout, sum} = a + b + cin, exact modulo 2^(WIDTH+1). No saturation.
  - Wrap-around: a=FF, b=01, cin=0 gives sum=00, cout=1.
- Internal structure:
  - Per-bit generate g=a&b and propagate p=a^b.
  - 4-bit carry-lookahead groups, with group carries rippled between groups.
  - sum_next = p ^ carries.
  - cout = carry out of the last group.
  - The result must be bit-identical to a behavioural a+b+cin for all 2^(2*WIDTH+1) input combinations.
- X/unknown inputs need not be handled; behaviour is defined only for 0/1 inputs.
- Before the first reset edge, outputs are undefined.
- Boundary conditions:
  - a=b=00, cin=0 gives 00, cout=0.
  - a=b=FF, cin=1 gives sum=FF, cout=1 (maximum value 0x1FF).
  - cin is the only source of +1 when a=b=0.
- ovf is computed from the same sampled operands and updated on the same edge as sum.

Test Plan:
- Hold rst=1 for 2 cycles with a=FF, b=FF, cin=1 -> sum=00000000, cout=0, ovf=0 after each edge. Release rst; one edge later -> sum=11111111, cout=1, ovf=0.
- a=00000011, b=00000101, cin=0 -> next edge: sum=00001000, cout=0. Then same operands with cin=1 -> sum=00001001, cout=0.
- a=11111111, b=00000001, cin=0 -> sum=00000000, cout=1, ovf=0. Then a=01111111, b=00000001, cin=0 -> sum=10000000, cout=0, ovf=1.
- Back-to-back vectors on consecutive edges (10101010+01010101+1, then 10000000+10000000+0):
  - First edge -> sum=00000000, cout=1, ovf=0.
  - Next edge -> sum=00000000, cout=1, ovf=1.
  - Confirms 1-cycle latency with no bubbles.
- Assert rst while a=00001111, b=00000001, cin=0 is applied -> that result never appears; outputs show 0. The next operand applied after release appears one edge later.
- File-driven sweep: read vectors "a b cin" in binary, one per clock. Log lines in the form "a b cin -> sum: <bin>, cout: <bin>" and compare against a golden model. Include an exhaustive pass over all a, b and cin (131072 vectors) with zero mismatches.
